// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS pipeline stages.
//   DATA_W    - datapath / register width
//   ADDR_W    - register address width
//   REG_ZERO  - address of the hard-wired zero register $0
//   word_t    - one datapath word
//   regaddr_t - one register address
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regaddr_t;

    localparam regaddr_t REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/wb_mux.sv
// wb_mux: write-back result select. Shared with the EX forwarding logic so
// both see exactly the same value for the W stage.
// Ports:
//   memtoregW  in  1 = pick load data, 0 = pick ALU result
//   readdataW  in  load data from MEM/WB
//   aluoutW    in  ALU result from MEM/WB
//   resultW    out selected write-back value (valid regardless of regwriW)
module wb_mux #(
    parameter int DATA_W = 32
) (
    input  logic              memtoregW,
    input  logic [DATA_W-1:0] readdataW,
    input  logic [DATA_W-1:0] aluoutW,
    output logic [DATA_W-1:0] resultW
);

    assign resultW = memtoregW ? readdataW : aluoutW;

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus the 32-entry architectural register file.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   regwriW, memtoregW,
//   readdataW, aluoutW,
//   wriregW                   MEM/WB pipeline-register outputs
//   ra1D, ra2D / rd1D, rd2D   ID-stage read ports with write-through bypass
//   resultW                   selected W-stage value for EX forwarding
//   dbg_addr / dbg_data       debug read of committed state (no bypass)
//   wb_count                  number of committed writes to nonzero registers
//   last_wreg                 destination of the most recent committed write
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwriW,
    input  logic              memtoregW,
    input  logic [DATA_W-1:0] readdataW,
    input  logic [DATA_W-1:0] aluoutW,
    input  logic [ADDR_W-1:0] wriregW,
    input  logic [ADDR_W-1:0] ra1D,
    input  logic [ADDR_W-1:0] ra2D,
    output logic [DATA_W-1:0] rd1D,
    output logic [DATA_W-1:0] rd2D,
    output logic [DATA_W-1:0] resultW,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wb_count,
    output logic [ADDR_W-1:0] last_wreg
);

    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .memtoregW (memtoregW),
        .readdataW (readdataW),
        .aluoutW   (aluoutW),
        .resultW   (resultW)
    );

    // Writes to $0 are dropped entirely: no array, counter or last_wreg update.
    assign commit = regwriW && (wriregW != ZERO_A);

    // Commit boundary: array, counter and last destination update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wb_count  <= '0;
            last_wreg <= '0;
        end else if (commit) begin
            regs[wriregW] <= resultW;
            wb_count      <= wb_count + 32'd1;
            last_wreg     <= wriregW;
        end
    end

    // Write-through bypass lets an ID read of the register being written this
    // cycle see the new value, so a WB->ID hazard needs no stall.
    always_comb begin
        rd1D = regs[ra1D];
        if (ra1D == ZERO_A) begin
            rd1D = '0;
        end else if (commit && (ra1D == wriregW)) begin
            rd1D = resultW;
        end
    end

    always_comb begin
        rd2D = regs[ra2D];
        if (ra2D == ZERO_A) begin
            rd2D = '0;
        end else if (commit && (ra2D == wriregW)) begin
            rd2D = resultW;
        end
    end

    assign dbg_data = (dbg_addr == ZERO_A) ? '0 : regs[dbg_addr];

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile against a behavioural
// register-file model (array + counter + last destination).
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriW, memtoregW;
    logic [31:0] readdataW, aluoutW;
    logic [4:0]  wriregW, ra1D, ra2D, dbg_addr;
    logic [31:0] rd1D, rd2D, resultW, dbg_data, wb_count;
    logic [4:0]  last_wreg;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [4:0]  m_last;

    wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .regwriW   (regwriW),
        .memtoregW (memtoregW),
        .readdataW (readdataW),
        .aluoutW   (aluoutW),
        .wriregW   (wriregW),
        .ra1D      (ra1D),
        .ra2D      (ra2D),
        .rd1D      (rd1D),
        .rd2D      (rd2D),
        .resultW   (resultW),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wb_count  (wb_count),
        .last_wreg (last_wreg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_result();
        return memtoregW ? readdataW : aluoutW;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (regwriW && wriregW != 5'd0 && ra == wriregW) return exp_result();
        return m_regs[ra];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt  = 32'd0;
        m_last = 5'd0;
    endtask

    // Applies one rising edge to the model using the currently driven inputs.
    task automatic model_edge();
        if (regwriW && wriregW != 5'd0) begin
            m_regs[wriregW] = exp_result();
            m_cnt  = m_cnt + 32'd1;
            m_last = wriregW;
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wr,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] da);
        regwriW = we; memtoregW = m2r; readdataW = rd; aluoutW = alu;
        wriregW = wr; ra1D = a1; ra2D = a2; dbg_addr = da;
    endtask

    // Present inputs after a falling edge, then clock once and settle.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd31, 5'd12);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wb_count !== 32'd0 || last_wreg !== 5'd0) begin
            errors++;
            $display("FAIL reset_counters got cnt=%h last=%0d want 0/0", wb_count, last_wreg);
        end
        checks++;
        if (rd1D !== 32'd0 || rd2D !== 32'd0 || dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_reads got rd1=%h rd2=%h dbg=%h want 0", rd1D, rd2D, dbg_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd8, 5'd1, 5'd2, 5'd8);
        tick();
        checks++;
        if (dbg_data !== 32'hDEAD_BEEF || wb_count !== 32'd1 || last_wreg !== 5'd8) begin
            errors++;
            $display("FAIL alu_write got dbg=%h cnt=%0d last=%0d want deadbeef/1/8",
                     dbg_data, wb_count, last_wreg);
        end
    endtask

    task automatic test_load_bypass();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0000_00FF, 32'hAAAA_5555, 5'd9, 5'd9, 5'd9, 5'd9);
        #1;
        checks++;
        if (rd1D !== 32'hFF || rd2D !== 32'hFF || resultW !== 32'hFF) begin
            errors++;
            $display("FAIL load_bypass got rd1=%h rd2=%h res=%h want ff", rd1D, rd2D, resultW);
        end
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL dbg_no_bypass got %h want 0", dbg_data);
        end
        tick();
        checks++;
        if (dbg_data !== 32'hFF || wb_count !== m_cnt) begin
            errors++;
            $display("FAIL load_commit got dbg=%h cnt=%0d want ff/%0d", dbg_data, wb_count, m_cnt);
        end
    endtask

    task automatic test_zero_protect();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd8, 5'd0);
        #1;
        checks++;
        if (rd1D !== 32'd0 || rd2D !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL zero_read got rd1=%h rd2=%h want 0/deadbeef", rd1D, rd2D);
        end
        tick();
        checks++;
        if (dbg_data !== 32'd0 || wb_count !== 32'd2 || last_wreg !== 5'd9) begin
            errors++;
            $display("FAIL zero_protect got dbg=%h cnt=%0d last=%0d want 0/2/9",
                     dbg_data, wb_count, last_wreg);
        end
    endtask

    task automatic test_disabled();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 32'h0000_0042, 5'd3, 5'd0, 5'd0, 5'd3);
        tick();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd7, 5'd3, 5'd3, 5'd3, 5'd3);
        #1;
        checks++;
        if (rd1D !== 32'h42 || resultW !== 32'd7) begin
            errors++;
            $display("FAIL disabled_read got rd1=%h res=%h want 42/7", rd1D, resultW);
        end
        tick();
        checks++;
        if (dbg_data !== 32'h42 || wb_count !== 32'd3 || last_wreg !== 5'd3) begin
            errors++;
            $display("FAIL disabled_hold got dbg=%h cnt=%0d last=%0d want 42/3/3",
                     dbg_data, wb_count, last_wreg);
        end
    endtask

    task automatic test_random();
        logic [4:0] wr;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            wr = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom, wr,
                  ($urandom_range(0, 2) == 0) ? wr : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? wr : 5'($urandom),
                  5'($urandom));
            #1;
            checks++;
            if (rd1D !== exp_read(ra1D) || rd2D !== exp_read(ra2D) || resultW !== exp_result()) begin
                errors++;
                $display("FAIL rand_read n=%0d got rd1=%h rd2=%h res=%h want %h/%h/%h", n,
                         rd1D, rd2D, resultW, exp_read(ra1D), exp_read(ra2D), exp_result());
            end
            checks++;
            if (dbg_data !== exp_dbg(dbg_addr)) begin
                errors++;
                $display("FAIL rand_dbg n=%0d addr=%0d got %h want %h", n, dbg_addr,
                         dbg_data, exp_dbg(dbg_addr));
            end
            tick();
            checks++;
            if (wb_count !== m_cnt || last_wreg !== m_last) begin
                errors++;
                $display("FAIL rand_state n=%0d got cnt=%0d last=%0d want %0d/%0d", n,
                         wb_count, last_wreg, m_cnt, m_last);
            end
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(a), 5'(31 - a), 5'(a));
            #1;
            checks++;
            if (dbg_data !== exp_dbg(5'(a)) || rd1D !== exp_read(5'(a))) begin
                errors++;
                $display("FAIL sweep reg=%0d got dbg=%h rd1=%h want %h", a, dbg_data, rd1D,
                         exp_dbg(5'(a)));
            end
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd1);
        force dut.wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (wb_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h want ffffffff", wb_count);
        end
        drive(1'b1, 1'b0, 32'd0, 32'h0BAD_F00D, 5'd1, 5'd0, 5'd0, 5'd1);
        tick();
        checks++;
        if (wb_count !== 32'd0 || last_wreg !== 5'd1 || dbg_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL counter_wrap got cnt=%h last=%0d dbg=%h want 0/1/0badf00d",
                     wb_count, last_wreg, dbg_data);
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 32'h0000_1234, 5'd5, 5'd0, 5'd0, 5'd5);
        tick();
        checks++;
        if (dbg_data !== 32'h1234) begin
            errors++;
            $display("FAIL midrun_write got %h want 1234", dbg_data);
        end
        @(negedge clk);
        #2;
        drive(1'b1, 1'b0, 32'd0, 32'h0000_5678, 5'd6, 5'd5, 5'd6, 5'd5);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dbg_data !== 32'd0 || wb_count !== 32'd0 || last_wreg !== 5'd0 || rd1D !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got dbg=%h cnt=%0d last=%0d rd1=%h want 0",
                     dbg_data, wb_count, last_wreg, rd1D);
        end
        @(posedge clk);
        #1;
        dbg_addr = 5'd6;
        #1;
        checks++;
        if (dbg_data !== 32'd0 || wb_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_priority got dbg=%h cnt=%0d want 0/0", dbg_data, wb_count);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (dbg_data !== 32'h5678 || wb_count !== 32'd1 || last_wreg !== 5'd6) begin
            errors++;
            $display("FAIL first_commit got dbg=%h cnt=%0d last=%0d want 5678/1/6",
                     dbg_data, wb_count, last_wreg);
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_bypass();
        test_zero_protect();
        test_disabled();
        test_random();
        test_counter_wrap();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file of the pipelined MIPS core.
- Consumes the MEM/WB pipeline-register outputs (regwriW, memtoregW, readdataW, aluoutW, wriregW).
- Selects the write-back result, commits it to a 32-entry register file, and serves the ID stage's two read ports with same-cycle write-through bypass.
- Exports the W-stage result for EX forwarding, plus a debug read port and retirement counters.

Parameters:
- DATA_W, 32, register and datapath width.
- ADDR_W, 5, register address width.
- NREGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- regwriW  in  1  write-back enable from MEM/WB.
- memtoregW  in  1  1 = commit readdataW, 0 = commit aluoutW.
- readdataW  in  DATA_W  load data from MEM/WB.
- aluoutW  in  DATA_W  ALU result from MEM/WB.
- wriregW  in  ADDR_W  destination register.
- ra1D  in  ADDR_W  ID read address, port 1 (rs).
- ra2D  in  ADDR_W  ID read address, port 2 (rt).
- rd1D  out  DATA_W  read data, port 1.
- rd2D  out  DATA_W  read data, port 2.
- resultW  out  DATA_W  selected write-back value, for EX forwarding.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data; no bypass applied.
- wb_count  out  32  number of committed writes to a nonzero register.
- last_wreg  out  ADDR_W  destination of the most recent committed write.

Behaviour:
- resultW = memtoregW ? readdataW : aluoutW. Combinational; valid even when regwriW=0.
- Commit condition: regwriW=1 and wriregW!=0. On the rising clk edge when it holds:
  - regs[wriregW] <= resultW;
  - wb_count <= wb_count+1, wrapping 0xFFFFFFFF -> 0;
  - last_wreg <= wriregW.
- Write to $0: no state change at all. Array, wb_count and last_wreg all hold.
- regwriW=0: no state change regardless of the other W inputs.
- Read ports are combinational:
  - rdN = 0 if raN==0;
  - else resultW if the commit condition holds and raN==wriregW (write-through bypass, so a same-cycle WB->ID hazard needs no stall);
  - else regs[raN].
- Both read ports may bypass simultaneously when ra1D==ra2D==wriregW.
- dbg_data = regs[dbg_addr], with regs[0] reading as 0. Shows committed state only.
- Reset (asynchronous assert, takes effect without a clock edge):
  - all regs = 0; wb_count = 0; last_wreg = 0;
  - rd1D, rd2D and dbg_data therefore read 0 unless bypass applies.
  - Reset takes priority over a write on the same edge; the write is lost.
- Reset deassert: the first commit occurs on the first rising edge with rst=0.
- Latency: a write is visible via bypass in the cycle it is presented, and from the array in the next cycle.
- No X propagation: the array and counters are fully initialised by reset, and regs[0] is never written.

Decomposition:
- Shared package mips_pkg holds:
  - constants DATA_W=32, ADDR_W=5, REG_ZERO=5'd0;
  - typedefs word_t [DATA_W-1:0] and regaddr_t [ADDR_W-1:0].
- One sub-module: wb_mux (the resultW 2:1 select), shared with the forwarding logic.
- The register array, bypass and counters stay in wb_regfile.

Test Plan:
- Reset mid-run: write $5=0x1234, then assert rst with no clock edge -> dbg_addr=5 gives 0, wb_count=0, last_wreg=0 immediately.
- ALU write: regwriW=1, memtoregW=0, aluoutW=0xDEADBEEF, wriregW=8, one edge -> dbg_data($8)=0xDEADBEEF, wb_count=1, last_wreg=8.
- Load write with bypass: memtoregW=1, readdataW=0x0000_00FF, wriregW=9, ra1D=ra2D=9 before the edge -> rd1D=rd2D=0xFF in the same cycle; after the edge dbg($9)=0xFF.
- $0 protection: regwriW=1, wriregW=0, aluoutW=0xFFFFFFFF, ra1D=0 -> rd1D=0, dbg($0)=0, wb_count and last_wreg unchanged.
- Disabled write: regwriW=0, wriregW=3, aluoutW=7, ra1D=3 -> rd1D keeps the old $3, resultW=7, no state change.
- Counter wrap: force wb_count to 0xFFFFFFFF via 2^32 commits or a backdoor, then one commit to $1 -> wb_count=0.
